// File: rtl/pu_riscv_pmachk_arbiter_if.sv
// Bundle of request, checker and response signals around the shared PMA checker.
// The arbiter uses the slave view; requesters, checker and response consumer use the master view.
interface pu_riscv_pmachk_arbiter_if #(
  parameter int PLEN = 64
);
  logic            if_req_i;
  logic            if_rdy_o;
  logic [PLEN-1:0] if_adr_i;
  logic [2:0]      if_size_i;
  logic            if_misaligned_i;

  logic            dm_req_i;
  logic            dm_rdy_o;
  logic [PLEN-1:0] dm_adr_i;
  logic [2:0]      dm_size_i;
  logic            dm_we_i;
  logic            dm_lock_i;
  logic            dm_misaligned_i;

  logic            chk_req_o;
  logic            chk_instr_o;
  logic [PLEN-1:0] chk_adr_o;
  logic [2:0]      chk_size_o;
  logic            chk_we_o;
  logic            chk_lock_o;
  logic            chk_misal_o;
  logic [13:0]     chk_pma_i;
  logic            chk_exc_i;
  logic            chk_misal_i;
  logic [2:0]      chk_acc_i;

  logic            rsp_valid_o;
  logic            rsp_owner_o;
  logic            rsp_ready_i;
  logic [13:0]     rsp_pma_o;
  logic            rsp_exc_o;
  logic            rsp_misal_o;
  logic [2:0]      rsp_acc_o;

  modport slave (
    input  if_req_i, if_adr_i, if_size_i, if_misaligned_i,
    output if_rdy_o,
    input  dm_req_i, dm_adr_i, dm_size_i, dm_we_i, dm_lock_i, dm_misaligned_i,
    output dm_rdy_o,
    output chk_req_o, chk_instr_o, chk_adr_o, chk_size_o, chk_we_o, chk_lock_o, chk_misal_o,
    input  chk_pma_i, chk_exc_i, chk_misal_i, chk_acc_i,
    output rsp_valid_o, rsp_owner_o, rsp_pma_o, rsp_exc_o, rsp_misal_o, rsp_acc_o,
    input  rsp_ready_i
  );

  modport master (
    output if_req_i, if_adr_i, if_size_i, if_misaligned_i,
    input  if_rdy_o,
    output dm_req_i, dm_adr_i, dm_size_i, dm_we_i, dm_lock_i, dm_misaligned_i,
    input  dm_rdy_o,
    input  chk_req_o, chk_instr_o, chk_adr_o, chk_size_o, chk_we_o, chk_lock_o, chk_misal_o,
    output chk_pma_i, chk_exc_i, chk_misal_i, chk_acc_i,
    input  rsp_valid_o, rsp_owner_o, rsp_pma_o, rsp_exc_o, rsp_misal_o, rsp_acc_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/pu_riscv_pmachk_arbiter.sv
// Shares one PMA checker between instruction fetch and data memory requesters:
// round-robin arbitration with AMO lock priority, one registered check, valid/ready verdict return.
module pu_riscv_pmachk_arbiter #(
  parameter int PLEN = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  pu_riscv_pmachk_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   lock_hold;
  logic   accept_open;
  logic   dm_wins_tie;
  logic   grant_if;
  logic   grant_dm;

  // New work is taken only when the checker slot is free and any pending verdict is being consumed.
  always_comb begin
    accept_open = !rst_i && ((state == IDLE) || ((state == RESP) && bus.rsp_ready_i));
    dm_wins_tie = lock_hold || !last_grant;
    grant_dm    = accept_open && bus.dm_req_i && (!bus.if_req_i || dm_wins_tie);
    grant_if    = accept_open && bus.if_req_i && !grant_dm;
  end

  assign bus.if_rdy_o = grant_if;
  assign bus.dm_rdy_o = grant_dm;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      last_grant      <= 1'b0;
      lock_hold       <= 1'b0;
      bus.chk_req_o   <= 1'b0;
      bus.chk_instr_o <= 1'b0;
      bus.chk_adr_o   <= '0;
      bus.chk_size_o  <= 3'b000;
      bus.chk_we_o    <= 1'b0;
      bus.chk_lock_o  <= 1'b0;
      bus.chk_misal_o <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_owner_o <= 1'b0;
      bus.rsp_pma_o   <= 14'h0000;
      bus.rsp_exc_o   <= 1'b0;
      bus.rsp_misal_o <= 1'b0;
      bus.rsp_acc_o   <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if || grant_dm) begin
            state         <= CHECK;
            bus.chk_req_o <= 1'b1;
          end
        end
        CHECK: begin
          state           <= RESP;
          bus.chk_req_o   <= 1'b0;
          bus.rsp_valid_o <= 1'b1;
          bus.rsp_owner_o <= ~bus.chk_instr_o;
          bus.rsp_pma_o   <= bus.chk_pma_i;
          bus.rsp_exc_o   <= bus.chk_exc_i;
          bus.rsp_misal_o <= bus.chk_misal_i;
          bus.rsp_acc_o   <= bus.chk_acc_i;
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            if (grant_if || grant_dm) begin
              state         <= CHECK;
              bus.chk_req_o <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Fetch never writes or locks; a fetch grant also releases any AMO priority.
      if (grant_if) begin
        bus.chk_instr_o <= 1'b1;
        bus.chk_adr_o   <= bus.if_adr_i;
        bus.chk_size_o  <= bus.if_size_i;
        bus.chk_we_o    <= 1'b0;
        bus.chk_lock_o  <= 1'b0;
        bus.chk_misal_o <= bus.if_misaligned_i;
        last_grant      <= 1'b0;
        lock_hold       <= 1'b0;
      end else if (grant_dm) begin
        bus.chk_instr_o <= 1'b0;
        bus.chk_adr_o   <= bus.dm_adr_i;
        bus.chk_size_o  <= bus.dm_size_i;
        bus.chk_we_o    <= bus.dm_we_i;
        bus.chk_lock_o  <= bus.dm_lock_i;
        bus.chk_misal_o <= bus.dm_misaligned_i;
        last_grant      <= 1'b1;
        lock_hold       <= bus.dm_lock_i;
      end
    end
  end

endmodule

// File: tb/tb_pu_riscv_pmachk_arbiter.sv
// Self-checking bench for pu_riscv_pmachk_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_pu_riscv_pmachk_arbiter;

  localparam int PLEN = 64;

  typedef struct packed {
    logic            instr;
    logic [PLEN-1:0] adr;
    logic [2:0]      size;
    logic            we;
    logic            lock;
    logic            misal;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pu_riscv_pmachk_arbiter_if #(.PLEN(PLEN)) bus ();

  pu_riscv_pmachk_arbiter #(.PLEN(PLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Reference model: one transaction in the checker slot, one verdict awaiting its owner.
  bit          m_check_valid = 1'b0;
  bit          m_resp_valid  = 1'b0;
  bit          m_last_dm     = 1'b0;
  bit          m_lock        = 1'b0;
  chk_t        m_hold        = '0;
  logic        m_resp_owner  = 1'b0;
  logic [13:0] m_pma         = '0;
  logic        m_exc         = 1'b0;
  logic        m_misal       = 1'b0;
  logic [2:0]  m_acc         = '0;

  // Returns {data_granted, fetch_granted} for the current inputs.
  function automatic logic [1:0] model_grant();
    logic open;
    open = !rst && !m_check_valid && (!m_resp_valid || bus.rsp_ready_i);
    if (!open) return 2'b00;
    if (bus.dm_req_i && bus.if_req_i) return (m_lock || !m_last_dm) ? 2'b10 : 2'b01;
    return {bus.dm_req_i, bus.if_req_i};
  endfunction

  always @(posedge clk) begin : model
    logic [1:0] g;
    g = model_grant();
    if (rst) begin
      m_check_valid = 1'b0;
      m_resp_valid  = 1'b0;
      m_last_dm     = 1'b0;
      m_lock        = 1'b0;
      m_hold        = '0;
      m_resp_owner  = 1'b0;
      m_pma         = '0;
      m_exc         = 1'b0;
      m_misal       = 1'b0;
      m_acc         = '0;
    end else begin
      if (m_check_valid) begin
        m_resp_valid = 1'b1;
        m_resp_owner = !m_hold.instr;
        m_pma        = bus.chk_pma_i;
        m_exc        = bus.chk_exc_i;
        m_misal      = bus.chk_misal_i;
        m_acc        = bus.chk_acc_i;
      end else if (m_resp_valid && bus.rsp_ready_i) begin
        m_resp_valid = 1'b0;
      end
      m_check_valid = (g != 2'b00);
      if (g[1]) begin
        m_hold    = '{1'b0, bus.dm_adr_i, bus.dm_size_i, bus.dm_we_i, bus.dm_lock_i, bus.dm_misaligned_i};
        m_last_dm = 1'b1;
        m_lock    = bus.dm_lock_i;
      end else if (g[0]) begin
        m_hold    = '{1'b1, bus.if_adr_i, bus.if_size_i, 1'b0, 1'b0, bus.if_misaligned_i};
        m_last_dm = 1'b0;
        m_lock    = 1'b0;
      end
    end
  end

  task automatic clear_inputs();
    bus.if_req_i        = 1'b0;
    bus.if_adr_i        = '0;
    bus.if_size_i       = 3'b000;
    bus.if_misaligned_i = 1'b0;
    bus.dm_req_i        = 1'b0;
    bus.dm_adr_i        = '0;
    bus.dm_size_i       = 3'b000;
    bus.dm_we_i         = 1'b0;
    bus.dm_lock_i       = 1'b0;
    bus.dm_misaligned_i = 1'b0;
    bus.chk_pma_i       = '0;
    bus.chk_exc_i       = 1'b0;
    bus.chk_misal_i     = 1'b0;
    bus.chk_acc_i       = 3'b000;
    bus.rsp_ready_i     = 1'b0;
  endtask

  // Leaves the caller at a falling edge, reset released, design idle.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [PLEN+39:0] outs;
    do_reset();
    #1;
    outs = {bus.if_rdy_o, bus.dm_rdy_o, bus.chk_req_o, bus.chk_instr_o, bus.chk_adr_o,
            bus.chk_size_o, bus.chk_we_o, bus.chk_lock_o, bus.chk_misal_o, bus.rsp_valid_o,
            bus.rsp_owner_o, bus.rsp_pma_o, bus.rsp_exc_o, bus.rsp_misal_o, bus.rsp_acc_o};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    end
  endtask

  task automatic test_fetch_single();
    do_reset();
    bus.if_req_i  = 1'b1;
    bus.if_adr_i  = 64'h0000_0000_8000_0000;
    bus.if_size_i = 3'b010;
    #1;
    vectors++;
    if ({bus.dm_rdy_o, bus.if_rdy_o} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL fetch_accept: got rdy %b expected 01", {bus.dm_rdy_o, bus.if_rdy_o});
    end
    @(negedge clk);
    bus.if_req_i  = 1'b0;
    bus.chk_acc_i = 3'b001;
    bus.chk_pma_i = 14'h1234;
    #1;
    vectors++;
    if ({bus.chk_req_o, bus.chk_instr_o, bus.chk_adr_o, bus.chk_size_o} !== {1'b1, 1'b1, 64'h8000_0000, 3'b010}) begin
      miscompares++;
      $display("[TB] FAIL fetch_check: got req %b instr %b adr %h size %0d expected 1 1 80000000 2",
               bus.chk_req_o, bus.chk_instr_o, bus.chk_adr_o, bus.chk_size_o);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({bus.rsp_valid_o, bus.rsp_owner_o, bus.rsp_acc_o, bus.rsp_pma_o, bus.rsp_exc_o, bus.chk_req_o}
        !== {1'b1, 1'b0, 3'b001, 14'h1234, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL fetch_resp: got valid %b owner %b acc %b pma %h exc %b chk_req %b expected 1 0 001 1234 0 0",
               bus.rsp_valid_o, bus.rsp_owner_o, bus.rsp_acc_o, bus.rsp_pma_o, bus.rsp_exc_o, bus.chk_req_o);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (bus.rsp_valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fetch_consumed: got valid %b expected 0", bus.rsp_valid_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    bus.if_req_i    = 1'b1;
    bus.dm_req_i    = 1'b1;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp = (i % 4 == 0) ? 2'b10 : (i % 4 == 2) ? 2'b01 : 2'b00;
      vectors++;
      if ({bus.dm_rdy_o, bus.if_rdy_o} !== exp) begin
        miscompares++;
        $display("[TB] FAIL round_robin[%0d]: got {dm,if} %b expected %b", i, {bus.dm_rdy_o, bus.if_rdy_o}, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
    logic [1:0] exp_tbl [0:6];
    exp_tbl = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    do_reset();
    bus.dm_req_i    = 1'b1;
    bus.dm_lock_i   = 1'b1;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      vectors++;
      if ({bus.dm_rdy_o, bus.if_rdy_o} !== exp_tbl[i]) begin
        miscompares++;
        $display("[TB] FAIL lock_grant[%0d]: got {dm,if} %b expected %b", i, {bus.dm_rdy_o, bus.if_rdy_o}, exp_tbl[i]);
      end
      @(negedge clk);
      bus.if_req_i  = 1'b1;
      bus.dm_lock_i = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] verdict;
    do_reset();
    bus.if_req_i = 1'b1;
    bus.dm_req_i = 1'b1;
    #1;
    vectors++;
    if ({bus.dm_rdy_o, bus.if_rdy_o} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL bp_first_grant: got {dm,if} %b expected 10", {bus.dm_rdy_o, bus.if_rdy_o});
    end
    @(negedge clk);
    verdict = 20'($urandom);
    {bus.chk_pma_i, bus.chk_exc_i, bus.chk_misal_i, bus.chk_acc_i} = {verdict[19:6], verdict[5], verdict[4], verdict[2:0]};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      {bus.chk_pma_i, bus.chk_exc_i, bus.chk_misal_i, bus.chk_acc_i} = 19'($urandom);
      #1;
      vectors++;
      if ({bus.rsp_valid_o, bus.rsp_owner_o, bus.rsp_pma_o, bus.rsp_exc_o, bus.rsp_misal_o, bus.rsp_acc_o,
           bus.dm_rdy_o, bus.if_rdy_o}
          !== {1'b1, 1'b1, verdict[19:6], verdict[5], verdict[4], verdict[2:0], 2'b00}) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d]: got valid %b owner %b pma %h exc %b mis %b acc %b rdy %b%b expected 1 1 %h %b %b %b 00",
                 k, bus.rsp_valid_o, bus.rsp_owner_o, bus.rsp_pma_o, bus.rsp_exc_o, bus.rsp_misal_o,
                 bus.rsp_acc_o, bus.dm_rdy_o, bus.if_rdy_o, verdict[19:6], verdict[5], verdict[4], verdict[2:0]);
      end
    end
    @(negedge clk);
    bus.rsp_ready_i = 1'b1;
    #1;
    vectors++;
    if ({bus.dm_rdy_o, bus.if_rdy_o} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL bp_release_grant: got {dm,if} %b expected 01", {bus.dm_rdy_o, bus.if_rdy_o});
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({bus.rsp_valid_o, bus.chk_req_o, bus.chk_instr_o} !== 3'b011) begin
      miscompares++;
      $display("[TB] FAIL bp_next_check: got valid %b chk_req %b instr %b expected 0 1 1",
               bus.rsp_valid_o, bus.chk_req_o, bus.chk_instr_o);
    end
  endtask

  task automatic test_exception();
    do_reset();
    bus.dm_req_i = 1'b1;
    bus.dm_we_i  = 1'b1;
    bus.dm_adr_i = 64'h10;
    #1;
    vectors++;
    if (bus.dm_rdy_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL exc_accept: got dm_rdy %b expected 1", bus.dm_rdy_o);
    end
    @(negedge clk);
    bus.dm_req_i  = 1'b0;
    bus.chk_exc_i = 1'b1;
    #1;
    vectors++;
    if ({bus.chk_req_o, bus.chk_we_o, bus.chk_instr_o, bus.chk_adr_o} !== {1'b1, 1'b1, 1'b0, 64'h10}) begin
      miscompares++;
      $display("[TB] FAIL exc_check: got req %b we %b instr %b adr %h expected 1 1 0 10",
               bus.chk_req_o, bus.chk_we_o, bus.chk_instr_o, bus.chk_adr_o);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({bus.rsp_valid_o, bus.rsp_exc_o, bus.rsp_owner_o} !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL exc_resp: got valid %b exc %b owner %b expected 1 1 1",
               bus.rsp_valid_o, bus.rsp_exc_o, bus.rsp_owner_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.dm_req_i = 1'b1;
    #1;
    vectors++;
    if (bus.dm_rdy_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_accept: got dm_rdy %b expected 1", bus.dm_rdy_o);
    end
    @(negedge clk);
    rst          = 1'b1;
    bus.if_req_i = 1'b1;
    #1;
    vectors++;
    if (bus.chk_req_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_in_check: got chk_req %b expected 1", bus.chk_req_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.rsp_valid_o, bus.chk_req_o, bus.dm_rdy_o, bus.if_rdy_o} !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL rstmid_after: got valid %b chk_req %b rdy {dm,if} %b%b expected 0 0 10",
               bus.rsp_valid_o, bus.chk_req_o, bus.dm_rdy_o, bus.if_rdy_o);
    end
  endtask

  task automatic test_random();
    bit         if_pend = 1'b0;
    bit         dm_pend = 1'b0;
    logic [1:0] g;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if (!if_pend) begin
        bus.if_req_i        = ($urandom_range(0, 9) < 6);
        bus.if_adr_i        = {$urandom, $urandom};
        bus.if_size_i       = 3'($urandom);
        bus.if_misaligned_i = 1'($urandom);
        if_pend             = bus.if_req_i;
      end
      if (!dm_pend) begin
        bus.dm_req_i        = ($urandom_range(0, 9) < 6);
        bus.dm_adr_i        = {$urandom, $urandom};
        bus.dm_size_i       = 3'($urandom);
        bus.dm_we_i         = 1'($urandom);
        bus.dm_lock_i       = ($urandom_range(0, 3) == 0);
        bus.dm_misaligned_i = 1'($urandom);
        dm_pend             = bus.dm_req_i;
      end
      {bus.chk_pma_i, bus.chk_exc_i, bus.chk_misal_i, bus.chk_acc_i} = 19'($urandom);
      bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
      rst             = ($urandom_range(0, 99) == 0);
      #1;
      g = model_grant();
      vectors++;
      if ({bus.dm_rdy_o, bus.if_rdy_o} !== g) begin
        miscompares++;
        $display("[TB] FAIL rand_rdy[%0d]: got {dm,if} %b expected %b", n, {bus.dm_rdy_o, bus.if_rdy_o}, g);
      end
      vectors++;
      if ({bus.chk_req_o, bus.chk_instr_o, bus.chk_adr_o, bus.chk_size_o, bus.chk_we_o, bus.chk_lock_o, bus.chk_misal_o}
          !== {m_check_valid, m_hold}) begin
        miscompares++;
        $display("[TB] FAIL rand_chk[%0d]: got %h expected %h", n,
                 {bus.chk_req_o, bus.chk_instr_o, bus.chk_adr_o, bus.chk_size_o, bus.chk_we_o, bus.chk_lock_o, bus.chk_misal_o},
                 {m_check_valid, m_hold});
      end
      vectors++;
      if ({bus.rsp_valid_o, bus.rsp_owner_o, bus.rsp_pma_o, bus.rsp_exc_o, bus.rsp_misal_o, bus.rsp_acc_o}
          !== {m_resp_valid, m_resp_owner, m_pma, m_exc, m_misal, m_acc}) begin
        miscompares++;
        $display("[TB] FAIL rand_rsp[%0d]: got %h expected %h", n,
                 {bus.rsp_valid_o, bus.rsp_owner_o, bus.rsp_pma_o, bus.rsp_exc_o, bus.rsp_misal_o, bus.rsp_acc_o},
                 {m_resp_valid, m_resp_owner, m_pma, m_exc, m_misal, m_acc});
      end
      if (g[0]) if_pend = 1'b0;
      if (g[1]) dm_pend = 1'b0;
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fetch_single();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_exception();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
